// File: rtl/lut_layer_scheduler.sv
// lut_layer_scheduler
//
// Evaluates the NUM_NEURONS neurons of one LogicNets layer on a single shared,
// runtime-loadable truth-table RAM, one neuron per clock. An accepted activation
// vector is held in a feature register. Each neuron gathers its FAN_IN features
// through the connectivity table and looks up its truth table. Each OUT_BITS
// result is packed into out_data at the neuron's slot.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    activation vector handshake
//   in_data              feature f at in_data[f*IN_BITS +: IN_BITS]
//   out_valid/out_ready  result vector handshake
//   out_data             neuron n at out_data[n*OUT_BITS +: OUT_BITS]
//   cfg_we, cfg_sel      config write strobe; 0 = truth table, 1 = connectivity
//   cfg_addr             truth table:  {neuron, lut_addr}
//                        connectivity: {neuron, slot}; neuron in the same top
//                        field as for the truth table, slot in the low AW bits
//   cfg_wdata            LSB-aligned write data (LUT value or feature index)
//   cfg_err              one-cycle pulse when a config write is rejected
//   busy                 high while neurons are being evaluated (RUN, DRAIN)
//
// Slot 0 of a neuron drives the MSBs of its LUT address; slot FAN_IN-1 drives
// the LSBs. Table storage has no reset and survives rst_n.

module lut_layer_scheduler #(
    parameter int NUM_NEURONS  = 8,
    parameter int NUM_FEATURES = 16,
    parameter int FAN_IN       = 4,
    parameter int IN_BITS      = 2,
    parameter int OUT_BITS     = 2,
    localparam int AW          = FAN_IN * IN_BITS,
    localparam int NW          = $clog2(NUM_NEURONS),
    localparam int FW          = $clog2(NUM_FEATURES),
    localparam int CFG_AW      = NW + AW,
    localparam int WD          = (OUT_BITS > FW) ? OUT_BITS : FW
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_FEATURES*IN_BITS-1:0]  in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0]  out_data,
    input  logic                             cfg_we,
    input  logic                             cfg_sel,
    input  logic [CFG_AW-1:0]                cfg_addr,
    input  logic [WD-1:0]                    cfg_wdata,
    output logic                             cfg_err,
    output logic                             busy
);

    localparam int CW = $clog2(NUM_NEURONS * FAN_IN);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic [NW-1:0]                   cnt;
    logic [NUM_FEATURES*IN_BITS-1:0] feat;

    logic [FW-1:0]       conn_mem [NUM_NEURONS*FAN_IN];
    logic [OUT_BITS-1:0] lut_mem  [NUM_NEURONS*(2**AW)];

    logic [AW-1:0]       gather_addr;
    logic [OUT_BITS-1:0] lut_p1;
    logic                vld_p1;
    logic [NW-1:0]       idx_p1;

    logic          accept;
    logic          handshake;
    logic          last_issue;
    logic [NW-1:0] cfg_neuron;
    logic [AW-1:0] cfg_slot;
    logic [CW-1:0] conn_widx;
    logic          conn_ok;
    logic          lut_we;
    logic          conn_we;
    logic          cfg_reject;

    // Config decode: writes only land in IDLE; connectivity writes must name
    // an existing slot and an existing feature.
    assign cfg_neuron = cfg_addr[CFG_AW-1 -: NW];
    assign cfg_slot   = cfg_addr[AW-1:0];
    assign conn_widx  = CW'(int'(cfg_neuron) * FAN_IN + int'(cfg_slot));
    assign conn_ok    = (int'(cfg_slot) < FAN_IN) && (int'(cfg_wdata) < NUM_FEATURES);
    assign lut_we     = cfg_we && (state == IDLE) && !cfg_sel;
    assign conn_we    = cfg_we && (state == IDLE) && cfg_sel && conn_ok;
    assign cfg_reject = cfg_we && ((state != IDLE) || (cfg_sel && !conn_ok));

    // A config write in IDLE takes priority over a vector in the same cycle.
    assign in_ready   = (state == IDLE) && !cfg_we;
    assign accept     = in_valid && in_ready;
    assign handshake  = out_valid && out_ready;
    assign last_issue = (cnt == NW'(NUM_NEURONS - 1));
    assign busy       = (state == RUN) || (state == DRAIN);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = RUN;
            RUN:     if (last_issue) state_nxt = DRAIN;
            DRAIN:                   state_nxt = DONE;
            DONE:    if (handshake)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= '0;
            else if (state == RUN)
                cnt <= cnt + NW'(1);
            vld_p1    <= (state == RUN);
            // out_valid comes from a flop; the first DONE cycle lets out_data
            // settle before it is presented.
            out_valid <= (state == DONE) && !handshake;
            cfg_err   <= cfg_reject;
        end
    end

    // Stage p0: gather the current neuron's features into its LUT address
    always_comb begin
        gather_addr = '0;
        for (int s = 0; s < FAN_IN; s++) begin
            logic [CW-1:0] cidx;
            int            fidx;
            cidx = CW'(int'(cnt) * FAN_IN + s);
            fidx = int'(conn_mem[cidx]);
            gather_addr[AW-1-s*IN_BITS -: IN_BITS] = feat[fidx*IN_BITS +: IN_BITS];
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            feat <= in_data;
        if (conn_we)
            conn_mem[conn_widx] <= cfg_wdata[FW-1:0];
        if (lut_we)
            lut_mem[cfg_addr] <= cfg_wdata[OUT_BITS-1:0];
    end

    // Stage p1: registered truth-table read, tagged with its neuron index
    always_ff @(posedge clk) begin
        lut_p1 <= lut_mem[{cnt, gather_addr}];
        idx_p1 <= cnt;
    end

    // Stage p2: pack the returned result into its out_data slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                if (vld_p1 && (idx_p1 == NW'(n)))
                    out_data[n*OUT_BITS +: OUT_BITS] <= lut_p1;
            end
        end
    end

endmodule

// File: tb/tb_lut_layer_scheduler.sv
module tb_lut_layer_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        cfg_we;
    logic        cfg_sel;
    logic [10:0] cfg_addr;
    logic [3:0]  cfg_wdata;
    logic        cfg_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    lut_layer_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_err   (cfg_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single config write; err returns cfg_err one cycle after the write edge.
    task automatic cfg_write(input logic sel, input logic [10:0] addr,
                             input logic [3:0] data, output logic err);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        err = cfg_err;
    endtask

    // Counts edges until out_valid (bounded); tracks whether in_ready stayed low.
    task automatic wait_out(output int lat, output logic ir_low);
        lat = 0;
        ir_low = 1'b1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (in_ready) ir_low = 1'b0;
        end
    endtask

    task automatic run_vec(input logic [31:0] v, output logic [15:0] res,
                           output int lat, output logic ir_low);
        @(negedge clk);
        in_valid = 1'b1; in_data = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat, ir_low);
        res = out_data;
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] res;
        logic [15:0] held;
        int          lat;
        logic        ir_low;
        logic        err;
        logic        stable;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // Every LUT entry of neuron n holds n mod 4; in-range connectivity
        @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            for (int a = 0; a < 256; a++) begin
                cfg_we = 1'b1; cfg_sel = 1'b0;
                cfg_addr = {3'(n), 8'(a)}; cfg_wdata = 4'(n % 4);
                @(negedge clk);
            end
        end
        for (int n = 0; n < 8; n++) begin
            for (int s = 0; s < 4; s++) begin
                cfg_we = 1'b1; cfg_sel = 1'b1;
                cfg_addr = {3'(n), 8'(s)}; cfg_wdata = 4'((n * 3 + s * 5) % 16);
                @(negedge clk);
            end
        end
        cfg_we = 1'b0;
        #1;
        chk("conn_fill_no_err", cfg_err, 1'b0);

        run_vec(32'h9C3A_571E, res, lat, ir_low);
        chk("distinct_data", res, 16'hE4E4);
        chk("distinct_latency", lat, 10);
        chk("distinct_in_ready_low", ir_low, 1'b1);
        chk("done_busy", busy, 1'b0);
        ack();
        chk("ack_out_valid", out_valid, 1'b0);

        // Reference neuron 0: conn {0,1,2,3}, only lut_addr 8'hC0 holds 01
        @(negedge clk);
        for (int a = 0; a < 256; a++) begin
            cfg_we = 1'b1; cfg_sel = 1'b0;
            cfg_addr = {3'd0, 8'(a)}; cfg_wdata = (a == 8'hC0) ? 4'd1 : 4'd0;
            @(negedge clk);
        end
        for (int s = 0; s < 4; s++) begin
            cfg_we = 1'b1; cfg_sel = 1'b1;
            cfg_addr = {3'd0, 8'(s)}; cfg_wdata = 4'(s);
            @(negedge clk);
        end
        cfg_we = 1'b0;

        run_vec(32'h0000_0003, res, lat, ir_low);
        chk("ref_f0_3_slot0", {30'd0, res[1:0]}, 32'd1);
        chk("ref_f0_3_full", res, 16'hE4E5);
        ack();
        run_vec(32'h0000_0002, res, lat, ir_low);
        chk("ref_f0_2_slot0", {30'd0, res[1:0]}, 32'd0);
        chk("ref_f0_2_full", res, 16'hE4E4);
        ack();

        // Latency and a held result while out_ready stays low
        run_vec(32'h0000_0003, res, lat, ir_low);
        chk("hs_latency", lat, 10);
        chk("hs_in_ready_low", ir_low, 1'b1);
        held = out_data;
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        chk("hs_held_stable", stable, 1'b1);
        chk("hs_held_data", held, 16'hE4E5);
        ack();
        chk("hs_in_ready_after", in_ready, 1'b1);
        chk("hs_out_valid_after", out_valid, 1'b0);

        // Config write during RUN is dropped and flagged
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h0000_0003;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = {3'd0, 8'hC0}; cfg_wdata = 4'd2;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        chk("run_cfg_err_pulse", cfg_err, 1'b1);
        @(posedge clk); #1;
        chk("run_cfg_err_clear", cfg_err, 1'b0);
        wait_out(lat, ir_low);
        chk("run_cfg_result", out_data, 16'hE4E5);
        ack();
        run_vec(32'h0000_0003, res, lat, ir_low);
        chk("run_cfg_rerun", res, 16'hE4E5);
        ack();

        // Connectivity writes with an out-of-range slot, then a legal one
        cfg_write(1'b1, {3'd0, 8'd4}, 4'd1, err);
        chk("conn_bad_slot_err", err, 1'b1);
        cfg_write(1'b1, {3'd0, 8'd0}, 4'd0, err);
        chk("conn_good_no_err", err, 1'b0);

        // cfg_we and in_valid together: write first, vector next cycle
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = {3'd0, 8'h80}; cfg_wdata = 4'd3;
        in_valid = 1'b1; in_data = 32'h0000_0002;
        #1;
        chk("prio_in_ready_low", in_ready, 1'b0);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        #1;
        chk("prio_in_ready_next", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat, ir_low);
        chk("prio_latency", lat, 10);
        chk("prio_write_landed", out_data, 16'hE4E7);
        ack();

        // Asynchronous reset in RUN
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h0000_0003;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_run_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_out_data", out_data, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1'b1);
        run_vec(32'h0000_0003, res, lat, ir_low);
        chk("arst_rerun", res, 16'hE4E5);
        chk("arst_rerun_latency", lat, 10);
        ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
